// File: rtl/ps2_key_tracker_pkg.sv
// Shared definitions for the PS/2 key tracker.
//   state_t      : parser FSM state encoding
//   CODE_*       : prefix bytes (E0 extended, F0 break, E1 pause sequence)
//   DISC_*       : controller/keyboard response bytes that carry no key
//   E1_SKIP_LEN  : bytes following E1 that belong to the Pause sequence
//   is_discard() : true for bytes that are dropped when seen in IDLE
package ps2_key_tracker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PFX_E0,
    ST_PFX_F0,
    ST_PFX_E0F0,
    ST_SKIP_E1
  } state_t;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_E1 = 8'hE1;
  localparam logic [7:0] CODE_F0 = 8'hF0;

  localparam logic [7:0] DISC_00 = 8'h00;
  localparam logic [7:0] DISC_AA = 8'hAA;
  localparam logic [7:0] DISC_EE = 8'hEE;
  localparam logic [7:0] DISC_FA = 8'hFA;
  localparam logic [7:0] DISC_FE = 8'hFE;
  localparam logic [7:0] DISC_FC = 8'hFC;

  localparam logic [2:0] E1_SKIP_LEN = 3'd7;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == DISC_00) || (b == DISC_AA) || (b == DISC_EE) ||
           (b == DISC_FA) || (b == DISC_FE) || (b == DISC_FC);
  endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Byte and event bundle of the PS/2 key tracker.
//   byte_in/byte_valid/byte_ovf : scan-code stream from the PS/2 decoder
//   evt_*                       : one-cycle key event (code, ext, break)
//   held_*                      : newest held key and number of held keys
//   err                         : one-cycle timeout/overflow strobe
// master drives the byte stream, slave (the tracker) drives the results.
interface ps2_key_tracker_if;
  import ps2_key_tracker_pkg::*;

  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ovf;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [7:0] held_key;
  logic       held_ext;
  logic [2:0] held_cnt;
  logic       err;

  modport master (
    output byte_in, byte_valid, byte_ovf,
    input  evt_valid, evt_code, evt_ext, evt_break,
    input  held_key, held_ext, held_cnt, err
  );

  modport slave (
    input  byte_in, byte_valid, byte_ovf,
    output evt_valid, evt_code, evt_ext, evt_break,
    output held_key, held_ext, held_cnt, err
  );

endinterface

// File: rtl/ps2_held_table.sv
// Ordered table of currently held keys, slot 0 oldest.
//   sys_clk, rst_n : clock, async active-low reset
//   clear          : empty the table
//   insert         : append {ext,code} as newest unless already present;
//                    when full the oldest entry is dropped
//   remove         : delete the {ext,code} entry if present, compacting
//                    younger entries toward slot 0
//   code, ext      : key looked up / inserted / removed
//   newest_code/ext: newest entry, 0x00/0 when empty
//   count          : valid entries
//   hit            : {ext,code} is currently held (combinational)
module ps2_held_table
  import ps2_key_tracker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       insert,
  input  logic       remove,
  input  logic [7:0] code,
  input  logic       ext,
  output logic [7:0] newest_code,
  output logic       newest_ext,
  output logic [2:0] count,
  output logic       hit
);

  logic [7:0] code_q [DEPTH];
  logic       ext_q  [DEPTH];
  logic [2:0] cnt_q;
  logic [7:0] code_d [DEPTH];
  logic       ext_d  [DEPTH];
  logic [2:0] cnt_d;
  logic [2:0] hit_idx;

  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((3'(i) < cnt_q) && (code_q[i] == code) && (ext_q[i] == ext)) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  always_comb begin
    code_d = code_q;
    ext_d  = ext_q;
    cnt_d  = cnt_q;
    if (clear) begin
      cnt_d = 3'd0;
    end else if (remove && hit) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (3'(i) >= hit_idx) begin
          code_d[i] = code_q[i+1];
          ext_d[i]  = ext_q[i+1];
        end
      end
      cnt_d = cnt_q - 3'd1;
    end else if (insert && !hit) begin
      if (cnt_q == 3'(DEPTH)) begin
        // full: slide everything one slot older, losing slot 0
        for (int i = 0; i < DEPTH - 1; i++) begin
          code_d[i] = code_q[i+1];
          ext_d[i]  = ext_q[i+1];
        end
        code_d[DEPTH-1] = code;
        ext_d[DEPTH-1]  = ext;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (3'(i) == cnt_q) begin
            code_d[i] = code;
            ext_d[i]  = ext;
          end
        end
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        code_q[i] <= 8'h00;
        ext_q[i]  <= 1'b0;
      end
      cnt_q <= 3'd0;
    end else begin
      code_q <= code_d;
      ext_q  <= ext_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    newest_code = 8'h00;
    newest_ext  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (3'(i + 1) == cnt_q) begin
        newest_code = code_q[i];
        newest_ext  = ext_q[i];
      end
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code set 2 parser and held-key tracker.
//   sys_clk : system clock
//   rst_n   : async active-low reset
//   bus     : slave side of ps2_key_tracker_if (byte stream in, key
//             events, held-key status and error strobe out)
// Events and held status appear one cycle after the completing byte.
//
// state       | meaning
// ------------+---------------------------------------------------
// ST_IDLE     | waiting for a make code or a prefix
// ST_PFX_E0   | E0 seen, next byte is an extended make or F0
// ST_PFX_F0   | F0 seen, next byte is a break code
// ST_PFX_E0F0 | E0 F0 seen, next byte is an extended break code
// ST_SKIP_E1  | swallowing the remaining bytes of the Pause sequence
module ps2_key_tracker
  import ps2_key_tracker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int DEPTH          = 4
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  ps2_key_tracker_if.slave   bus
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state;
  logic [2:0]         skip_cnt;
  logic [TMR_W-1:0]   tmr;
  logic               evt_valid_q;
  logic [7:0]         evt_code_q;
  logic               evt_ext_q;
  logic               evt_break_q;
  logic               err_q;

  logic               tbl_insert;
  logic               tbl_remove;
  logic               tbl_ext;
  logic               tbl_hit;
  logic               tbl_event;

  // Decode of the byte being accepted this cycle; overflow suppresses it.
  always_comb begin
    tbl_insert = 1'b0;
    tbl_remove = 1'b0;
    tbl_ext    = 1'b0;
    if (bus.byte_valid && !bus.byte_ovf) begin
      unique case (state)
        ST_IDLE: begin
          if ((bus.byte_in != CODE_E0) && (bus.byte_in != CODE_F0) &&
              (bus.byte_in != CODE_E1) && !is_discard(bus.byte_in))
            tbl_insert = 1'b1;
        end
        ST_PFX_E0: begin
          if (bus.byte_in != CODE_F0) begin
            tbl_insert = 1'b1;
            tbl_ext    = 1'b1;
          end
        end
        ST_PFX_F0: tbl_remove = 1'b1;
        ST_PFX_E0F0: begin
          tbl_remove = 1'b1;
          tbl_ext    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A repeat make of a held key is silent; every break is reported.
  assign tbl_event = (tbl_insert && !tbl_hit) || tbl_remove;

  ps2_held_table #(.DEPTH(DEPTH)) u_held_table (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .clear       (bus.byte_ovf),
    .insert      (tbl_insert),
    .remove      (tbl_remove),
    .code        (bus.byte_in),
    .ext         (tbl_ext),
    .newest_code (bus.held_key),
    .newest_ext  (bus.held_ext),
    .count       (bus.held_cnt),
    .hit         (tbl_hit)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      skip_cnt    <= 3'd0;
      tmr         <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 8'h00;
      evt_ext_q   <= 1'b0;
      evt_break_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      evt_valid_q <= 1'b0;
      err_q       <= 1'b0;
      if (bus.byte_ovf) begin
        state    <= ST_IDLE;
        skip_cnt <= 3'd0;
        tmr      <= '0;
        err_q    <= 1'b1;
      end else if (bus.byte_valid) begin
        tmr <= TMR_W'(TIMEOUT_CYCLES);
        if (tbl_event) begin
          evt_valid_q <= 1'b1;
          evt_code_q  <= bus.byte_in;
          evt_ext_q   <= tbl_ext;
          evt_break_q <= tbl_remove;
        end
        unique case (state)
          ST_IDLE: begin
            if (bus.byte_in == CODE_E0)
              state <= ST_PFX_E0;
            else if (bus.byte_in == CODE_F0)
              state <= ST_PFX_F0;
            else if (bus.byte_in == CODE_E1) begin
              state    <= ST_SKIP_E1;
              skip_cnt <= E1_SKIP_LEN;
            end
          end
          ST_PFX_E0: begin
            if (bus.byte_in == CODE_F0)
              state <= ST_PFX_E0F0;
            else
              state <= ST_IDLE;
          end
          ST_PFX_F0, ST_PFX_E0F0: state <= ST_IDLE;
          ST_SKIP_E1: begin
            skip_cnt <= skip_cnt - 3'd1;
            if (skip_cnt == 3'd1)
              state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        // tmr holds the cycles still allowed before the sequence is abandoned
        if (tmr <= TMR_W'(1)) begin
          state    <= ST_IDLE;
          skip_cnt <= 3'd0;
          tmr      <= '0;
          err_q    <= 1'b1;
        end else begin
          tmr <= tmr - TMR_W'(1);
        end
      end
    end
  end

  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_code  = evt_code_q;
  assign bus.evt_ext   = evt_ext_q;
  assign bus.evt_break = evt_break_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Testbench for ps2_key_tracker: directed scenarios with literal
// expectations followed by randomized byte streams, all checked every
// cycle against a queue-based reference model of the key tracker.
module tb_ps2_key_tracker;

  localparam int TO    = 40;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ps2_key_tracker_if bus ();

  ps2_key_tracker #(.TIMEOUT_CYCLES(TO), .DEPTH(DEPTH)) dut (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int evt_seen = 0;
  int err_seen = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic       exp_evt_valid = 1'b0;
  logic [7:0] exp_evt_code  = 8'h00;
  logic       exp_evt_ext   = 1'b0;
  logic       exp_evt_break = 1'b0;
  logic       exp_err       = 1'b0;
  bit         m_e0 = 0;
  bit         m_f0 = 0;
  int         m_skip = 0;
  int         m_gap = 0;
  logic [8:0] m_held[$];

  function automatic void m_emit(logic [7:0] b, logic e, logic brk);
    exp_evt_valid = 1'b1;
    exp_evt_code  = b;
    exp_evt_ext   = e;
    exp_evt_break = brk;
  endfunction

  function automatic int m_find(logic [8:0] k);
    int idx;
    idx = -1;
    foreach (m_held[i]) if (m_held[i] == k) idx = i;
    return idx;
  endfunction

  function automatic void m_make(logic [7:0] b, logic e);
    if (m_find({e, b}) < 0) begin
      m_emit(b, e, 1'b0);
      if (m_held.size() == DEPTH) void'(m_held.pop_front());
      m_held.push_back({e, b});
    end
  endfunction

  function automatic void m_break(logic [7:0] b, logic e);
    int idx;
    m_emit(b, e, 1'b1);
    idx = m_find({e, b});
    if (idx >= 0) m_held.delete(idx);
  endfunction

  function automatic void m_byte(logic [7:0] b);
    if (m_skip > 0) begin
      m_skip--;
    end else if (m_f0) begin
      m_break(b, m_e0);
      m_e0 = 0;
      m_f0 = 0;
    end else if (m_e0) begin
      if (b == 8'hF0) m_f0 = 1;
      else begin
        m_make(b, 1'b1);
        m_e0 = 0;
      end
    end else begin
      case (b)
        8'hE0: m_e0 = 1;
        8'hF0: m_f0 = 1;
        8'hE1: m_skip = 7;
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFC: ;
        default: m_make(b, 1'b0);
      endcase
    end
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_e0 = 0; m_f0 = 0; m_skip = 0; m_gap = 0;
      m_held.delete();
      exp_evt_valid = 1'b0; exp_evt_code = 8'h00;
      exp_evt_ext = 1'b0; exp_evt_break = 1'b0; exp_err = 1'b0;
    end else begin
      exp_evt_valid = 1'b0;
      exp_err       = 1'b0;
      if (bus.byte_ovf) begin
        m_e0 = 0; m_f0 = 0; m_skip = 0; m_gap = 0;
        m_held.delete();
        exp_err = 1'b1;
      end else if (bus.byte_valid) begin
        m_gap = 0;
        m_byte(bus.byte_in);
      end else if (m_e0 || m_f0 || (m_skip > 0)) begin
        m_gap++;
        if (m_gap == TO) begin
          m_e0 = 0; m_f0 = 0; m_skip = 0; m_gap = 0;
          exp_err = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    logic [8:0] newest;
    @(negedge clk);
    newest = (m_held.size() > 0) ? m_held[m_held.size()-1] : 9'h000;
    chk("evt_valid", 32'(bus.evt_valid), 32'(exp_evt_valid));
    if (exp_evt_valid) begin
      chk("evt_code", 32'(bus.evt_code), 32'(exp_evt_code));
      chk("evt_ext", 32'(bus.evt_ext), 32'(exp_evt_ext));
      chk("evt_break", 32'(bus.evt_break), 32'(exp_evt_break));
    end
    chk("held_key", 32'(bus.held_key), 32'(newest[7:0]));
    chk("held_ext", 32'(bus.held_ext), 32'(newest[8]));
    chk("held_cnt", 32'(bus.held_cnt), 32'(m_held.size()));
    chk("err", 32'(bus.err), 32'(exp_err));
    if (bus.evt_valid === 1'b1) evt_seen++;
    if (bus.err === 1'b1) err_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    #1;
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i]);
  endtask

  task automatic ovf_pulse();
    @(negedge clk);
    bus.byte_ovf = 1'b1;
    @(negedge clk);
    bus.byte_ovf = 1'b0;
    #1;
  endtask

  function automatic logic [7:0] pick_byte();
    logic [7:0] keys [8];
    logic [7:0] disc [3];
    int r;
    keys = '{8'h1C, 8'h1D, 8'h15, 8'h24, 8'h2D, 8'h2C, 8'h75, 8'h12};
    disc = '{8'h00, 8'hAA, 8'hFA};
    r = $urandom_range(0, 99);
    if (r < 12) return 8'hE0;
    if (r < 26) return 8'hF0;
    if (r < 28) return 8'hE1;
    if (r < 32) return disc[$urandom_range(0, 2)];
    return keys[$urandom_range(0, 7)];
  endfunction

  initial begin
    int n0;
    int e0;
    int r;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.byte_ovf   = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_evt_valid", 32'(bus.evt_valid), 0);
    chk("rst_held_key", 32'(bus.held_key), 0);
    chk("rst_held_cnt", 32'(bus.held_cnt), 0);
    chk("rst_err", 32'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // press / release
    send(8'h1C);
    chk("p1_valid", 32'(bus.evt_valid), 1);
    chk("p1_code", 32'(bus.evt_code), 32'h1C);
    chk("p1_break", 32'(bus.evt_break), 0);
    chk("p1_held_key", 32'(bus.held_key), 32'h1C);
    chk("p1_held_cnt", 32'(bus.held_cnt), 1);
    send(8'hF0);
    chk("f0_silent", 32'(bus.evt_valid), 0);
    send(8'h1C);
    chk("r1_valid", 32'(bus.evt_valid), 1);
    chk("r1_break", 32'(bus.evt_break), 1);
    chk("r1_held_key", 32'(bus.held_key), 0);
    chk("r1_held_cnt", 32'(bus.held_cnt), 0);

    // extended press / release
    send_seq('{8'hE0, 8'h75});
    chk("e_press_code", 32'(bus.evt_code), 32'h75);
    chk("e_press_ext", 32'(bus.evt_ext), 1);
    chk("e_held_ext", 32'(bus.held_ext), 1);
    send_seq('{8'hE0, 8'hF0, 8'h75});
    chk("e_rel_break", 32'(bus.evt_break), 1);
    chk("e_rel_ext", 32'(bus.evt_ext), 1);
    chk("e_rel_cnt", 32'(bus.held_cnt), 0);

    // typematic repeat
    n0 = evt_seen;
    send_seq('{8'h1C, 8'h1C, 8'h1C});
    chk("typematic_events", 32'(evt_seen - n0), 1);
    chk("typematic_cnt", 32'(bus.held_cnt), 1);
    send_seq('{8'hF0, 8'h1C});

    // table overflow and compaction
    send_seq('{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C});
    chk("full_cnt", 32'(bus.held_cnt), 4);
    chk("full_key", 32'(bus.held_key), 32'h2C);
    send_seq('{8'hF0, 8'h2C});
    chk("brk_newest_key", 32'(bus.held_key), 32'h2D);
    send_seq('{8'hF0, 8'h15});
    chk("brk_absent_valid", 32'(bus.evt_valid), 1);
    chk("brk_absent_code", 32'(bus.evt_code), 32'h15);
    chk("brk_absent_cnt", 32'(bus.held_cnt), 3);
    ovf_pulse();
    chk("ovf_err", 32'(bus.err), 1);
    chk("ovf_cnt", 32'(bus.held_cnt), 0);

    // timeout after a break prefix
    send(8'hF0);
    n0 = evt_seen;
    e0 = err_seen;
    repeat (TO + 5) @(negedge clk);
    #1;
    chk("to_err_pulses", 32'(err_seen - e0), 1);
    chk("to_no_evt", 32'(evt_seen - n0), 0);
    send(8'h1C);
    chk("to_next_valid", 32'(bus.evt_valid), 1);
    chk("to_next_press", 32'(bus.evt_break), 0);
    send_seq('{8'hF0, 8'h1C});

    // Pause sequence swallowed
    n0 = evt_seen;
    send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
    chk("pause_no_evt", 32'(evt_seen - n0), 0);
    send(8'h1C);
    chk("pause_next_valid", 32'(bus.evt_valid), 1);
    chk("pause_next_code", 32'(bus.evt_code), 32'h1C);
    chk("pause_next_press", 32'(bus.evt_break), 0);

    // overflow together with a byte: byte is lost
    @(negedge clk);
    bus.byte_in = 8'h2D; bus.byte_valid = 1'b1; bus.byte_ovf = 1'b1;
    @(negedge clk);
    bus.byte_valid = 1'b0; bus.byte_ovf = 1'b0;
    #1;
    chk("ovf_byte_no_evt", 32'(bus.evt_valid), 0);
    chk("ovf_byte_err", 32'(bus.err), 1);
    chk("ovf_byte_cnt", 32'(bus.held_cnt), 0);

    // reset in the middle of an E0 prefix
    send(8'hE0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'h75);
    chk("rst_mid_valid", 32'(bus.evt_valid), 1);
    chk("rst_mid_ext", 32'(bus.evt_ext), 0);
    send_seq('{8'hF0, 8'h75});

    // randomized streams, including back-to-back bytes and long gaps
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      r = $urandom_range(0, 999);
      bus.byte_ovf   = (r < 4);
      bus.byte_valid = ($urandom_range(0, 9) < 6);
      bus.byte_in    = pick_byte();
      if (n == 2500) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      if (r >= 4 && r < 14) begin
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_ovf   = 1'b0;
        repeat (TO - 3 + $urandom_range(0, 3)) @(negedge clk);
      end
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_ovf   = 1'b0;
    repeat (3) @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
